mmio_uart_bridge: RTL
=====================

// Module: mmio_uart_bridge
// PURPOSE
// - Bus initiator for the SoC memory-mapped peripheral interface (valid/ready, addr, wrstb, wdata, rdata).
// - Parses a byte command stream from a UART receiver and issues single 32-bit reads and writes to peripherals such as the GPIO block.
// - Returns status and read data as a byte stream to a UART transmitter.
// - Used as a board bring-up/debug port that drives peripherals without the CPU.
// PARAMETERS
// - TIMEOUT  default 64  bus cycles to wait for bus_ready before aborting; 0 disables the timeout.
// PORTS
// - clk        in   1   clock
// - resetn     in   1   asynchronous, active-low reset
// - rx_data    in   8   received command byte
// - rx_valid   in   1   1-cycle strobe, rx_data valid; no backpressure
// - tx_data    out  8   response byte
// - tx_valid   out  1   response byte valid; held until tx_ready
// - tx_ready   in   1   transmitter accepts tx_data this cycle
// - bus_addr   out  32  peripheral address
// - bus_wrstb  out  4   byte write strobes; 4'hF for write, 4'h0 for read
// - bus_wdata  out  32  write data
// - bus_rdata  in   32  read data, valid in the cycle bus_ready=1
// - bus_valid  out  1   transaction request; held until bus_ready or timeout
// - bus_ready  in   1   peripheral completion
// - busy       out  1   high in any state other than IDLE
// - overrun    out  1   1-cycle pulse when an rx byte is dropped
// BEHAVIOUR
// - Reset: all outputs are 0, FSM=IDLE, byte counter=0, timeout counter=0.
// - Reset asserted mid-transaction aborts immediately. No response byte is sent.
// - Command format (multi-byte fields are LSB first):
//   - Write: 0x57 ('W'), A0..A3, D0..D3.
//   - Read:  0x52 ('R'), A0..A3.
// - FSM states: IDLE, ADDR, WDATA, BUS, RESP.
// - IDLE, on rx_valid:
//   - 0x57 or 0x52: latch op, go to ADDR, counter=0.
//   - Any other byte: load tx_data=0x3F ('?'), go to RESP.
// - ADDR: each rx byte fills bus_addr[8*cnt+:8]. After byte 3 (cnt wraps 3->0):
//   - Write: go to WDATA.
//   - Read: go to BUS.
// - WDATA: each rx byte fills bus_wdata[8*cnt+:8]. After byte 3, go to BUS.
// - BUS:
//   - bus_valid rises in the cycle after the last command byte is accepted. bus_wrstb is set in that same cycle.
//   - bus_addr, bus_wdata and bus_wrstb stay stable while bus_valid=1.
//   - On the first edge with bus_valid=1 and bus_ready=1: clear bus_valid and bus_wrstb on the next cycle.
//     - Read: capture bus_rdata into the response register.
//     - Write: load response 0x4B ('K').
//     - Then go to RESP.
//   - A ready that stays high after valid drops (registered-ready peripherals) is ignored. Exactly one transaction is issued per command.
//   - Timeout (TIMEOUT!=0): if bus_valid has been high for TIMEOUT cycles with no bus_ready, clear bus_valid and load 0x54 ('T'), then go to RESP. bus_ready arriving in the same cycle as expiry wins.
// - RESP:
//   - tx_valid rises the cycle after entry. tx_data is stable until tx_valid and tx_ready are both 1.
//   - Read sends 4 bytes, rdata[7:0] first. Status responses send 1 byte.
//   - After the last handshake: tx_valid=0, go to IDLE.
// - rx_valid in BUS or RESP: the byte is dropped, overrun pulses for 1 cycle, and the FSM is unaffected.
// - A new command is accepted in the first IDLE cycle after the final tx handshake.
// - busy=1 whenever state!=IDLE.
// TESTING
// 1. Write: rx 57 04 00 00 00 5A 00 00 00, slave ready 1 cycle after valid -> addr=0x4, wdata=0x5A, wrstb=F, one valid pulse of 2 cycles, tx 0x4B.
// 2. Read: rx 52 08 00 00 00, slave returns 0x000000A5 -> wrstb=0 throughout, tx A5 00 00 00 in order.
// 3. Registered ready held high 3 cycles after valid -> exactly one transaction is counted by the bench.
// 4. Timeout: TIMEOUT=16, bus_ready tied 0 -> bus_valid high exactly 16 cycles, then tx 0x54, busy drops after the handshake.
// 5. Backpressure, bad opcode, overrun: tx_ready low 10 cycles holds tx_data; rx 0x41 -> tx 0x3F; an rx byte sent during BUS -> overrun pulse with no effect on the transaction.
// 6. resetn pulsed low during the BUS state -> all outputs 0 at once; a following read command completes normally.

Source files
------------

// File: rtl/mmio_uart_bridge.sv
// rtl/mmio_uart_bridge.sv - UART byte-command to memory-mapped bus initiator
module mmio_uart_bridge #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_wrstb,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_RESP} state_t;

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wrstb_q, wrstb_d;
    logic          bvalid_q, bvalid_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    rlast_q, rlast_d;
    logic          txv_q, txv_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          ovr_q, ovr_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wrstb_q  <= '0;
            bvalid_q <= 1'b0;
            resp_q   <= '0;
            rlast_q  <= '0;
            txv_q    <= 1'b0;
            tmo_q    <= '0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wrstb_q  <= wrstb_d;
            bvalid_q <= bvalid_d;
            resp_q   <= resp_d;
            rlast_q  <= rlast_d;
            txv_q    <= txv_d;
            tmo_q    <= tmo_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wrstb_d  = wrstb_q;
        bvalid_d = bvalid_q;
        resp_d   = resp_q;
        rlast_d  = rlast_q;
        txv_d    = txv_q;
        tmo_d    = tmo_q;
        ovr_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == 8'h57 || rx_data == 8'h52) begin
                        wr_d    = (rx_data == 8'h57);
                        cnt_d   = 2'd0;
                        state_d = S_ADDR;
                    end else begin
                        resp_d  = 32'h0000_003F;
                        rlast_d = 2'd0;
                        txv_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d[8*cnt_q +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (wr_q) begin
                            state_d = S_WDATA;
                        end else begin
                            state_d  = S_BUS;
                            bvalid_d = 1'b1;
                            wrstb_d  = 4'h0;
                            tmo_d    = '0;
                        end
                    end
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    wdata_d[8*cnt_q +: 8] = rx_data;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d  = S_BUS;
                        bvalid_d = 1'b1;
                        wrstb_d  = 4'hF;
                        tmo_d    = '0;
                    end
                end
            end
            S_BUS: begin
                ovr_d = rx_valid;
                // Ready is checked before expiry so a completion on the last cycle still wins.
                if (bvalid_q && bus_ready) begin
                    bvalid_d = 1'b0;
                    wrstb_d  = 4'h0;
                    resp_d   = wr_q ? 32'h0000_004B : bus_rdata;
                    rlast_d  = wr_q ? 2'd0 : 2'd3;
                    txv_d    = 1'b1;
                    state_d  = S_RESP;
                end else if (TIMEOUT != 0 && tmo_q == TMO_LAST) begin
                    bvalid_d = 1'b0;
                    wrstb_d  = 4'h0;
                    resp_d   = 32'h0000_0054;
                    rlast_d  = 2'd0;
                    txv_d    = 1'b1;
                    state_d  = S_RESP;
                end else if (TIMEOUT != 0) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RESP: begin
                ovr_d = rx_valid;
                if (txv_q && tx_ready) begin
                    if (rlast_q == 2'd0) begin
                        txv_d   = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        resp_d  = resp_q >> 8;
                        rlast_d = rlast_q - 2'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_data   = resp_q[7:0];
    assign tx_valid  = txv_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign bus_wrstb = wrstb_q;
    assign bus_valid = bvalid_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = ovr_q;

endmodule
